// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle between two Wishbone masters, the arbiter and one slave.
// slave modport: arbiter view (takes master requests); master modport: environment view.
interface wb_arbiter_2m_if #(
    parameter int DWIDTH = 32,
    parameter int SWIDTH = 4,
    parameter int AWIDTH = 30
);
    logic              i_m0_cyc, i_m1_cyc;
    logic              i_m0_stb, i_m1_stb;
    logic              i_m0_we,  i_m1_we;
    logic [SWIDTH-1:0] i_m0_sel, i_m1_sel;
    logic [AWIDTH-1:0] i_m0_adr, i_m1_adr;
    logic [DWIDTH-1:0] i_m0_dat, i_m1_dat;
    logic [DWIDTH-1:0] o_m0_dat, o_m1_dat;
    logic              o_m0_ack, o_m1_ack;
    logic              o_m0_err, o_m1_err;
    logic              o_s_cyc, o_s_stb, o_s_we;
    logic [SWIDTH-1:0] o_s_sel;
    logic [AWIDTH-1:0] o_s_adr;
    logic [DWIDTH-1:0] o_s_dat;
    logic [DWIDTH-1:0] i_s_dat;
    logic              i_s_ack;
    logic [1:0]        o_gnt;

    modport slave (
        input  i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb,
        input  i_m0_we, i_m1_we, i_m0_sel, i_m1_sel,
        input  i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat,
        input  i_s_dat, i_s_ack,
        output o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack,
        output o_m0_err, o_m1_err,
        output o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat,
        output o_gnt
    );

    modport master (
        output i_m0_cyc, i_m1_cyc, i_m0_stb, i_m1_stb,
        output i_m0_we, i_m1_we, i_m0_sel, i_m1_sel,
        output i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat,
        output i_s_dat, i_s_ack,
        input  o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack,
        input  o_m0_err, o_m1_err,
        input  o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat,
        input  o_gnt
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with per-grant stall watchdog.
// Ports: i_ck, i_rst (sync, active-high), bus (wb_arbiter_2m_if.slave).
module wb_arbiter_2m #(
    parameter int DWIDTH   = 32,
    parameter int SWIDTH   = 4,
    parameter int AWIDTH   = 30,
    parameter int TO_WIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input logic           i_ck,
    input logic           i_rst,
    wb_arbiter_2m_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t              state, state_n;
    logic                last_gnt;
    logic [TO_WIDTH-1:0] cnt, cnt_n;

    logic              g_cyc, g_stb, g_we;
    logic [SWIDTH-1:0] g_sel;
    logic [AWIDTH-1:0] g_adr;
    logic [DWIDTH-1:0] g_dat;
    logic              hit, drive;

    logic              s_cyc, s_stb, s_we;
    logic [SWIDTH-1:0] s_sel;
    logic [AWIDTH-1:0] s_adr;
    logic [DWIDTH-1:0] s_dat;
    logic              m0_ack, m1_ack, m0_err, m1_err;

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state_n == GNT0 && state != GNT0)
                last_gnt <= 1'b0;
            else if (state_n == GNT1 && state != GNT1)
                last_gnt <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat   = '0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_err  = 1'b0;

        // Mux follows the registered grant, not the next one.
        g_cyc = (state == GNT1) ? bus.i_m1_cyc : bus.i_m0_cyc;
        g_stb = (state == GNT1) ? bus.i_m1_stb : bus.i_m0_stb;
        g_we  = (state == GNT1) ? bus.i_m1_we  : bus.i_m0_we;
        g_sel = (state == GNT1) ? bus.i_m1_sel : bus.i_m0_sel;
        g_adr = (state == GNT1) ? bus.i_m1_adr : bus.i_m0_adr;
        g_dat = (state == GNT1) ? bus.i_m1_dat : bus.i_m0_dat;

        hit = (TIMEOUT != 0) && (state != IDLE) &&
              (cnt == TO_WIDTH'(TIMEOUT)) && g_stb && !bus.i_s_ack;

        unique case (state)
            IDLE: begin
                if (bus.i_m0_cyc && bus.i_m1_cyc)
                    state_n = last_gnt ? GNT0 : GNT1;
                else if (bus.i_m0_cyc)
                    state_n = GNT0;
                else if (bus.i_m1_cyc)
                    state_n = GNT1;
            end
            GNT0: begin
                if (!bus.i_m0_cyc)
                    state_n = bus.i_m1_cyc ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!bus.i_m1_cyc)
                    state_n = bus.i_m0_cyc ? GNT0 : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Blank the slave in a release cycle that falls back to IDLE.
        drive = (state != IDLE) && !(!g_cyc && state_n == IDLE);

        if (drive) begin
            s_cyc = g_cyc;
            s_stb = g_stb && !hit;
            s_we  = g_we;
            s_sel = g_sel;
            s_adr = g_adr;
            s_dat = g_dat;
        end

        if (state == GNT0) begin
            m0_ack = bus.i_s_ack && bus.i_m0_stb;
            m0_err = hit;
        end
        if (state == GNT1) begin
            m1_ack = bus.i_s_ack && bus.i_m1_stb;
            m1_err = hit;
        end

        // Stall counter restarts on any grant change, ack, idle strobe or hit.
        if (state != IDLE && state_n == state &&
            g_stb && !bus.i_s_ack && !hit)
            cnt_n = cnt + 1'b1;
    end

    assign bus.o_s_cyc  = s_cyc;
    assign bus.o_s_stb  = s_stb;
    assign bus.o_s_we   = s_we;
    assign bus.o_s_sel  = s_sel;
    assign bus.o_s_adr  = s_adr;
    assign bus.o_s_dat  = s_dat;
    assign bus.o_m0_ack = m0_ack;
    assign bus.o_m1_ack = m1_ack;
    assign bus.o_m0_err = m0_err;
    assign bus.o_m1_err = m1_err;
    assign bus.o_m0_dat = bus.i_s_dat;
    assign bus.o_m1_dat = bus.i_s_dat;
    assign bus.o_gnt    = {state == GNT1, state == GNT0};
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: u_a with TIMEOUT=4, u_b with TIMEOUT=0.
// All expectations are hand-computed constants.
module tb_wb_arbiter_2m;
    logic ck;
    logic rst;
    int total;
    int bad;

    wb_arbiter_2m_if #(.DWIDTH(32), .SWIDTH(4), .AWIDTH(30)) ia ();
    wb_arbiter_2m_if #(.DWIDTH(32), .SWIDTH(4), .AWIDTH(30)) ib ();

    wb_arbiter_2m #(.TIMEOUT(4)) u_a (
        .i_ck (ck),
        .i_rst(rst),
        .bus  (ia.slave)
    );

    wb_arbiter_2m #(.TIMEOUT(0)) u_b (
        .i_ck (ck),
        .i_rst(rst),
        .bus  (ib.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic idle_a();
        ia.i_m0_cyc = 0; ia.i_m0_stb = 0; ia.i_m0_we = 0;
        ia.i_m0_sel = '0; ia.i_m0_adr = '0; ia.i_m0_dat = '0;
        ia.i_m1_cyc = 0; ia.i_m1_stb = 0; ia.i_m1_we = 0;
        ia.i_m1_sel = '0; ia.i_m1_adr = '0; ia.i_m1_dat = '0;
        ia.i_s_ack = 0; ia.i_s_dat = '0;
    endtask

    task automatic idle_b();
        ib.i_m0_cyc = 0; ib.i_m0_stb = 0; ib.i_m0_we = 0;
        ib.i_m0_sel = '0; ib.i_m0_adr = '0; ib.i_m0_dat = '0;
        ib.i_m1_cyc = 0; ib.i_m1_stb = 0; ib.i_m1_we = 0;
        ib.i_m1_sel = '0; ib.i_m1_adr = '0; ib.i_m1_dat = '0;
        ib.i_s_ack = 0; ib.i_s_dat = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] w_dat [3];
        int errs;
        int gbad;
        total = 0;
        bad = 0;
        rst = 1;
        idle_a();
        idle_b();
        w_dat[0] = 32'h11;
        w_dat[1] = 32'h22;
        w_dat[2] = 32'h33;

        // reset state
        do_reset();
        @(negedge ck);
        check("rst_gnt", 64'(ia.o_gnt), 64'(0));
        check("rst_scyc", 64'(ia.o_s_cyc), 64'(0));
        check("rst_sstb", 64'(ia.o_s_stb), 64'(0));
        check("rst_acks", 64'({ia.o_m0_ack, ia.o_m1_ack,
                               ia.o_m0_err, ia.o_m1_err}), 64'(0));

        // m0 read at 0x10, ack one cycle after stb
        step();
        ia.i_m0_cyc = 1; ia.i_m0_stb = 1; ia.i_m0_sel = 4'hF;
        ia.i_m0_adr = 30'h10;
        @(negedge ck);
        check("rd_lat_gnt", 64'(ia.o_gnt), 64'(0));
        check("rd_lat_scyc", 64'(ia.o_s_cyc), 64'(0));
        step();
        @(negedge ck);
        check("rd_gnt", 64'(ia.o_gnt), 64'(1));
        check("rd_sstb", 64'(ia.o_s_stb), 64'(1));
        check("rd_sadr", 64'(ia.o_s_adr), 64'(30'h10));
        check("rd_noack", 64'(ia.o_m0_ack), 64'(0));
        step();
        ia.i_s_ack = 1; ia.i_s_dat = 32'hDEADBEEF;
        @(negedge ck);
        check("rd_ack", 64'(ia.o_m0_ack), 64'(1));
        check("rd_dat", 64'(ia.o_m0_dat), 64'(32'hDEADBEEF));
        check("rd_m1ack", 64'(ia.o_m1_ack), 64'(0));
        step();
        idle_a();
        @(negedge ck);
        check("rd_rel_gnt", 64'(ia.o_gnt), 64'(1));
        check("rd_rel_scyc", 64'(ia.o_s_cyc), 64'(0));
        check("rd_rel_sadr", 64'(ia.o_s_adr), 64'(0));
        step();
        @(negedge ck);
        check("rd_idle_gnt", 64'(ia.o_gnt), 64'(0));

        // simultaneous requests after reset: m0 first, then m1, then m0
        do_reset();
        ia.i_m0_cyc = 1; ia.i_m1_cyc = 1;
        ia.i_m1_adr = 30'h5;
        step();
        @(negedge ck);
        check("rr_first", 64'(ia.o_gnt), 64'(1));
        step();
        ia.i_m0_cyc = 0;
        @(negedge ck);
        check("rr_rel_hold", 64'(ia.o_gnt), 64'(1));
        step();
        @(negedge ck);
        check("rr_second", 64'(ia.o_gnt), 64'(2));
        check("rr_sadr", 64'(ia.o_s_adr), 64'(30'h5));
        step();
        ia.i_m1_cyc = 0;
        step();
        ia.i_m0_cyc = 1; ia.i_m1_cyc = 1;
        @(negedge ck);
        check("rr_idle", 64'(ia.o_gnt), 64'(0));
        step();
        @(negedge ck);
        check("rr_third", 64'(ia.o_gnt), 64'(1));
        step();
        idle_a();
        step();

        // m0 burst of three writes while m1 waits (last_gnt now 0)
        step();
        ia.i_m0_cyc = 1;
        step();
        ia.i_m1_cyc = 1; ia.i_m1_stb = 1; ia.i_m1_adr = 30'h2A;
        for (int i = 0; i < 3; i++) begin
            ia.i_m0_stb = 1; ia.i_m0_we = 1; ia.i_m0_sel = 4'hF;
            ia.i_m0_adr = 30'(i + 1);
            ia.i_m0_dat = w_dat[i];
            ia.i_s_ack = 1;
            @(negedge ck);
            check("wr_gnt", 64'(ia.o_gnt), 64'(1));
            check("wr_sadr", 64'(ia.o_s_adr), 64'(i + 1));
            check("wr_sdat", 64'(ia.o_s_dat), 64'(w_dat[i]));
            check("wr_swe", 64'(ia.o_s_we), 64'(1));
            check("wr_ack", 64'({ia.o_m1_ack, ia.o_m0_ack}), 64'(1));
            step();
        end
        ia.i_m0_cyc = 0; ia.i_m0_stb = 0; ia.i_m0_we = 0;
        ia.i_s_ack = 0;
        @(negedge ck);
        check("wr_rel_gnt", 64'(ia.o_gnt), 64'(1));
        check("wr_rel_scyc", 64'(ia.o_s_cyc), 64'(0));
        step();
        @(negedge ck);
        check("wr_m1_gnt", 64'(ia.o_gnt), 64'(2));
        check("wr_m1_sadr", 64'(ia.o_s_adr), 64'(30'h2A));
        step();
        idle_a();
        step();

        // watchdog: TIMEOUT=4, m1 strobe never acked
        step();
        ia.i_m1_cyc = 1; ia.i_m1_stb = 1; ia.i_m1_adr = 30'h3;
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge ck);
            check("to_err", 64'(ia.o_m1_err), 64'(k == 5));
            check("to_sstb", 64'(ia.o_s_stb), 64'(k != 5));
            check("to_gnt", 64'(ia.o_gnt), 64'(2));
        end
        step();
        ia.i_m1_stb = 0;
        step();
        @(negedge ck);
        check("to_hold_gnt", 64'(ia.o_gnt), 64'(2));
        step();
        ia.i_m1_cyc = 0;
        step();
        @(negedge ck);
        check("to_idle_gnt", 64'(ia.o_gnt), 64'(0));

        // reset during granted m1 read
        step();
        ia.i_m1_cyc = 1; ia.i_m1_stb = 1; ia.i_m1_adr = 30'h7;
        step();
        @(negedge ck);
        check("rm_gnt", 64'(ia.o_gnt), 64'(2));
        step();
        rst = 1;
        step();
        rst = 0;
        ia.i_s_ack = 1; ia.i_s_dat = 32'hCAFE0001;
        @(negedge ck);
        check("rm_gnt0", 64'(ia.o_gnt), 64'(0));
        check("rm_sout", 64'({ia.o_s_cyc, ia.o_s_stb, ia.o_s_we,
                              ia.o_s_sel, ia.o_s_adr}), 64'(0));
        check("rm_ackerr", 64'({ia.o_m1_ack, ia.o_m1_err}), 64'(0));
        step();
        ia.i_s_ack = 0;
        @(negedge ck);
        check("rm_regnt", 64'(ia.o_gnt), 64'(2));
        step();
        idle_a();
        step();

        // TIMEOUT=0: 300-cycle stall, no error, grant held
        ib.i_m0_cyc = 1; ib.i_m0_stb = 1; ib.i_m0_adr = 30'h9;
        step();
        errs = 0;
        gbad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge ck);
            if (ib.o_m0_err !== 1'b0) errs++;
            if (ib.o_gnt !== 2'b01) gbad++;
            step();
        end
        @(negedge ck);
        check("t0_errs", 64'(errs), 64'(0));
        check("t0_gnt_bad", 64'(gbad), 64'(0));
        check("t0_sstb", 64'(ib.o_s_stb), 64'(1));
        idle_b();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single-port memory_wb slave.
- Master 0 is the instruction-fetch port; master 1 is the load/store port.
- Grants are registered and held for a whole bus cycle (CYC high).
- Simultaneous requests are resolved round-robin.
- A per-grant watchdog returns an error to a master whose slave never acknowledges.
- Sits between the core's bus interfaces and the memory slave.

Parameters:
- DWIDTH, 32, data width.
- SWIDTH, 4, byte-select width.
- AWIDTH, 30, word address width.
- TO_WIDTH, 8, watchdog counter width.
- TIMEOUT, 255, stall cycles before error; 0 disables the watchdog; must be < 2**TO_WIDTH.

Ports:
- i_ck  in  1  clock
- i_rst  in  1  reset
- i_m0_cyc, i_m1_cyc  in  1  master bus-cycle request
- i_m0_stb, i_m1_stb  in  1  master strobe
- i_m0_we, i_m1_we  in  1  master write enable
- i_m0_sel, i_m1_sel  in  SWIDTH  master byte selects
- i_m0_adr, i_m1_adr  in  AWIDTH  master address
- i_m0_dat, i_m1_dat  in  DWIDTH  master write data
- o_m0_dat, o_m1_dat  out  DWIDTH  read data (both are i_s_dat)
- o_m0_ack, o_m1_ack  out  1  ack to master
- o_m0_err, o_m1_err  out  1  watchdog error to master
- o_s_cyc, o_s_stb, o_s_we  out  1  slave controls
- o_s_sel  out  SWIDTH  slave byte selects
- o_s_adr  out  AWIDTH  slave address
- o_s_dat  out  DWIDTH  slave write data
- i_s_dat  in  DWIDTH  slave read data
- i_s_ack  in  1  slave ack
- o_gnt  out  2  one-hot grant: bit0 = m0, bit1 = m1; 00 = idle

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state: state=IDLE, last_gnt=1, watchdog counter=0.
- Reset outputs: o_gnt=00; o_s_cyc, o_s_stb, o_s_we, o_s_sel, o_s_adr, o_s_dat all 0; all acks and errs 0.
- Read data: o_mX_dat = i_s_dat at all times; it is unregistered and valid only with the corresponding ack.
- State IDLE:
  - no cyc: stay IDLE.
  - only mX cyc: go to GNTX.
  - both cyc: grant the master that is not last_gnt.
  - Arbitration latency is one cycle: a request seen in IDLE at edge N drives the slave from cycle N+1.
- State GNTX (X=0/1):
  - o_gnt[X]=1.
  - o_s_cyc = i_mX_cyc.
  - o_s_stb = i_mX_stb & ~timeout_hit.
  - o_s_we/sel/adr/dat = mX signals (combinational mux).
  - o_mX_ack = i_s_ack & i_mX_stb.
  - The other master's ack and err are 0.
  - last_gnt <= X on entry.
- Release from GNTX when i_mX_cyc=0:
  - If the other master's cyc is 1, go directly to GNTother (no IDLE bubble).
  - Otherwise go to IDLE.
  - Slave outputs are 0 in the release cycle only if the next state is IDLE. In GNT states the mux follows the registered state.
- Non-preemption: the grant is never preempted while the granted cyc is high, regardless of the other request.
- Slave outputs in IDLE: all slave outputs 0; any i_s_ack is ignored and not routed.
- Slave timing: memory_wb acks writes in the same cycle and reads one cycle later. The arbiter adds no extra latency in GNT states; back-to-back transfers within one cyc pass through unchanged.
- Watchdog:
  - Counter increments each GNT cycle with stb=1 and i_s_ack=0.
  - Counter clears on ack, on stb=0, and on any state change.
  - timeout_hit = (TIMEOUT!=0) & (count==TIMEOUT) & stb & ~ack.
  - On timeout_hit: o_mX_err=1 for that cycle, o_s_stb forced 0, counter cleared next edge. The grant stays until the master drops cyc.
- Simultaneous ack and timeout: ack wins; err stays 0.
- Reset mid-transfer: returns to IDLE on the next edge; slave outputs drop to 0; any in-flight transfer is abandoned.

Test Plan:
- Reset, then m0 read at adr 0x10 (slave data 0xDEADBEEF, ack one cycle after stb) -> o_gnt=01 one cycle after cyc; o_m0_ack high with o_m0_dat=0xDEADBEEF; o_m1_ack stays 0.
- m0 and m1 raise cyc in the same cycle from IDLE after reset -> m0 granted first (last_gnt=1). When m0 drops cyc, m1 is granted the next cycle with no IDLE state between. A second simultaneous request then grants m0.
- m0 holds cyc for 3 back-to-back writes (sel 0xF, adr 1,2,3, data 0x11,0x22,0x33) while m1 requests -> m1 waits; 3 same-cycle acks go to m0; m1 is granted only after m0 cyc=0.
- TIMEOUT=4, slave never acks a m1 strobe -> o_m1_err pulses on the 5th stalled cycle; o_s_stb=0 that cycle; o_gnt stays 10 until m1 drops cyc.
- Reset asserted during a granted m1 read -> next edge o_gnt=00, all slave outputs 0, and no ack or err is emitted. A subsequent lone m1 request is granted normally.
- TIMEOUT=0, stall of 300 cycles -> no err; grant held throughout.
